wb_bram_burst: RTL

WB_BRAM_BURST -- requirements
Module: wb_bram_burst

---
 rtl/wb_bram_burst.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave with registered ack/err and single-cycle first-beat latency.
// Define WB_BRAM_BURST_EN to compile in incremental bursts (cti/bte); otherwise every beat is classic.
module wb_bram_burst #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int ADR_WIDTH     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic                    ack,
  output logic                    err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int DEPTH = 1 << MEM_ADR_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLASSIC = 2'd1;
`ifdef WB_BRAM_BURST_EN
  localparam logic [1:0] ST_BURST   = 2'd2;
  localparam logic [2:0] CTI_INCR   = 3'b010;
`endif

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [1:0]               state_q, state_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [MEM_ADR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    dat_sm_q;

  logic                     rd_en;
  logic [MEM_ADR_WIDTH-1:0] rd_idx;
  logic [MEM_ADR_WIDTH-1:0] adr_idx;
  logic                     out_of_range;
  logic                     wr_en;

  assign adr_idx      = adr[LSB +: MEM_ADR_WIDTH];
  assign out_of_range = (adr >> (LSB + MEM_ADR_WIDTH)) != '0;
  // addr_q always names the word of the beat currently being acked
  assign wr_en        = cyc & stb & we & ack_q;

`ifdef WB_BRAM_BURST_EN
  logic [MEM_ADR_WIDTH-1:0] wrap_mask;
  logic [MEM_ADR_WIDTH-1:0] next_idx;

  always_comb begin
    case (bte)
      2'b01:   wrap_mask = MEM_ADR_WIDTH'(3);
      2'b10:   wrap_mask = MEM_ADR_WIDTH'(7);
      2'b11:   wrap_mask = MEM_ADR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    next_idx = (addr_q & ~wrap_mask) | ((addr_q + MEM_ADR_WIDTH'(1)) & wrap_mask);
  end
`else
  logic unused_burst_ports;
  assign unused_burst_ports = ^{cti, bte};
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    rd_en   = 1'b0;
    rd_idx  = adr_idx;
    if (!cyc) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stb) begin
            if (out_of_range) begin
              err_d   = 1'b1;
              state_d = ST_CLASSIC;
            end else begin
              ack_d  = 1'b1;
              addr_d = adr_idx;
              rd_en  = ~we;
              rd_idx = adr_idx;
`ifdef WB_BRAM_BURST_EN
              state_d = (cti == CTI_INCR) ? ST_BURST : ST_CLASSIC;
`else
              state_d = ST_CLASSIC;
`endif
            end
          end
        end
        ST_CLASSIC: state_d = ST_IDLE;
`ifdef WB_BRAM_BURST_EN
        // Prefetch the predicted next word so data is ready with the next ack
        ST_BURST: begin
          if (stb && cti == CTI_INCR) begin
            ack_d  = 1'b1;
            addr_d = next_idx;
            rd_en  = ~we;
            rd_idx = next_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      dat_sm_q <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      if (rd_en) begin
        dat_sm_q <= mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (sel[b]) begin
          mem[addr_q][8*b +: 8] <= dat_ms[8*b +: 8];
        end
      end
    end
  end

  assign ack    = ack_q;
  assign err    = err_q;
  assign dat_sm = dat_sm_q;

endmodule
